// File: rtl/z80_daisy_arbiter.sv
// Z80 mode-2 interrupt arbiter for up to four daisy-chained channels.
// Latches request edges, resolves fixed priority, supplies the vector and tracks in-service state.
module z80_daisy_arbiter #(
    parameter int unsigned NCH = 4
) (
    input  logic           I_CLK,
    input  logic           I_RESET,
    input  logic           I_CLKEN,
    input  logic           I_IEI,
    input  logic [NCH-1:0] I_REQ,
    input  logic [NCH-1:0] I_IE,
    input  logic [7:0]     I_VBASE,
    input  logic           I_SPM1,
    input  logic           I_RETI,
    output logic           O_INT_n,
    output logic           O_IEO,
    output logic [7:0]     O_VEC,
    output logic           O_VEC_OE,
    output logic [NCH-1:0] O_ACK
);

    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_insvc;
    logic [NCH-1:0] r_req_d;
    logic [NCH-1:0] r_ack;
    logic           r_spm1_d;
    logic           r_int_n;
    logic           r_vec_oe;
    logic [7:0]     r_vec;

    logic [NCH-1:0] w_insvc_reti;
    logic [NCH-1:0] w_elig;
    logic [NCH-1:0] w_elig_post;
    logic [NCH-1:0] w_ack_oh;
    logic [NCH-1:0] w_pend_nxt;
    logic [NCH-1:0] w_insvc_nxt;
    logic [1:0]     w_win;
    logic           w_ack;

    // A channel is blocked by any in-service channel at or above it, or any enabled request above it.
    function automatic logic [NCH-1:0] f_elig(input logic [NCH-1:0] pend,
                                              input logic [NCH-1:0] ie,
                                              input logic [NCH-1:0] insvc,
                                              input logic           iei);
        logic [NCH-1:0] e;
        logic           blk;
        e   = '0;
        blk = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            blk  = blk | insvc[i];
            e[i] = pend[i] & ie[i] & iei & ~blk;
            blk  = blk | (pend[i] & ie[i]);
        end
        return e;
    endfunction

    always_comb begin
        w_insvc_reti = r_insvc;
        if (I_RETI && I_IEI) begin
            w_insvc_reti = r_insvc & ~(r_insvc & (~r_insvc + NCH'(1)));
        end
        w_elig = f_elig(r_pend, I_IE, w_insvc_reti, I_IEI);
        w_win  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_elig[NCH-1-i]) w_win = 2'(NCH-1-i);
        end
        w_ack       = I_SPM1 & ~r_spm1_d & ~r_int_n & (|w_elig);
        w_ack_oh    = w_ack ? (NCH'(1) << w_win) : '0;
        w_pend_nxt  = (r_pend & ~w_ack_oh) | (I_REQ & ~r_req_d);
        w_insvc_nxt = w_insvc_reti | w_ack_oh;
        // /INT reflects the state after this cycle's RETI and acknowledge have been applied.
        w_elig_post = f_elig(r_pend & ~w_ack_oh, I_IE, w_insvc_nxt, I_IEI);
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_pend   <= '0;
            r_insvc  <= '0;
            r_req_d  <= '0;
            r_ack    <= '0;
            r_spm1_d <= 1'b0;
            r_int_n  <= 1'b1;
            r_vec_oe <= 1'b0;
            r_vec    <= '0;
        end else if (I_CLKEN) begin
            r_pend   <= w_pend_nxt;
            r_insvc  <= w_insvc_nxt;
            r_req_d  <= I_REQ;
            r_ack    <= w_ack_oh;
            r_spm1_d <= I_SPM1;
            r_int_n  <= ~(|w_elig_post);
            if (w_ack) begin
                r_vec    <= {I_VBASE[7:3], w_win, 1'b0};
                r_vec_oe <= 1'b1;
            end else if (!I_SPM1) begin
                r_vec_oe <= 1'b0;
            end
        end
    end

    assign O_INT_n  = r_int_n;
    assign O_IEO    = I_IEI & ~(|r_insvc) & ~(|(r_pend & I_IE));
    assign O_VEC    = r_vec;
    assign O_VEC_OE = r_vec_oe;
    assign O_ACK    = r_ack;

endmodule

// File: doc/z80_daisy_arbiter.md
# z80_daisy_arbiter

Z80 mode-2 interrupt controller for up to four peripheral channels (e.g. CTC channels) on one daisy-chain position. It latches per-channel requests, picks a winner by fixed priority, drives /INT, supplies the vector during the interrupt-acknowledge cycle, tracks in-service state, and releases it on RETI. It sits between the peripheral channels and the CPU bus, fed by the RETI/SPM1 strobe decoder.

## Interface
- NCH, 4: number of channels, 1..4. Channel 0 has the highest priority.
- I_CLK  in  1  system clock.
- I_RESET  in  1  synchronous, active-high reset.
- I_CLKEN  in  1  clock enable. All state advances only on cycles where it is high.
- I_IEI  in  1  daisy-chain enable in. High means no upstream device is active.
- I_REQ  in  NCH  per-channel request lines. Each is rising-edge detected.
- I_IE  in  NCH  per-channel interrupt enable.
- I_VBASE  in  8  vector base. Only bits 7:3 are used.
- I_SPM1  in  1  interrupt-acknowledge level (M1 & IORQ).
- I_RETI  in  1  one-CLKEN-cycle strobe at the end of a decoded ED 4D.
- O_INT_n  out  1  registered /INT, active low.
- O_IEO  out  1  daisy-chain enable out.
- O_VEC  out  8  acknowledge vector.
- O_VEC_OE  out  1  vector drive enable.
- O_ACK  out  NCH  one-CLKEN-cycle pulse to the acknowledged channel.

## Operation
- **Per-channel state:** each channel i has two bits.
  - pend[i] is set by a 0→1 transition of I_REQ[i], sampled on CLKEN cycles. It is cleared when channel i is acknowledged. If a new edge and the acknowledge land in the same cycle, set wins.
  - insvc[i] is set on acknowledge and cleared by RETI.
- **Eligibility:** channel i is eligible when all of the following hold:
  - pend[i] & I_IE[i] & I_IEI;
  - no insvc[j] for any j ≤ i;
  - no pend[j] & I_IE[j] for any j < i.
  - Consequence: a higher-priority channel may nest over a lower in-service one. An equal or lower-priority channel may not.
- **Interrupt request:** O_INT_n <= ~|eligible, registered.
- **Daisy-chain out:** O_IEO = I_IEI & ~|insvc & ~|(pend & I_IE), combinational.
- **Acknowledge** (detected on a registered rising edge of I_SPM1):
  - If O_INT_n is low, the winner w is the lowest-index eligible channel. The block then:
    - latches w;
    - sets insvc[w] and clears pend[w];
    - pulses O_ACK[w];
    - loads O_VEC = {I_VBASE[7:3], w[1:0], 1'b0}.
  - If O_INT_n is high, nothing happens and O_VEC_OE stays low.
- **Vector drive:** O_VEC_OE is high from the acknowledge cycle until I_SPM1 is sampled low. O_VEC is held stable for that whole window.
- **RETI:**
  - With I_IEI high: clear the lowest-index set insvc bit.
  - With I_IEI low, or with no insvc bit set: ignore (an upstream device owns it).
- **I_IE low on a channel:** masks only. The pend bit is retained and fires when I_IE returns high.
- **Reset state:** pend=0, insvc=0, O_INT_n=1, O_VEC=8'h00, O_VEC_OE=0, O_ACK=0. O_IEO follows I_IEI.
- **Reset mid-acknowledge:** O_VEC_OE drops in the next cycle and all state is cleared.

## Timing
- Cycle numbering counts CLKEN cycles.
- I_REQ edge sampled at cycle k → pend set at k+1 → O_INT_n low at k+2.
- I_SPM1 first sampled high at cycle a → the following change at a+1:
  - O_VEC_OE goes high;
  - O_ACK pulses;
  - insvc is updated;
  - O_INT_n is re-evaluated.
- O_VEC_OE drops one cycle after I_SPM1 is sampled low.
- RETI strobe at cycle r → insvc cleared at r+1 → O_IEO rises at r+1 if nothing else is blocking it.
- **Simultaneous RETI and acknowledge:** the RETI clear is applied first, then the acknowledge set. A channel may therefore be re-acknowledged in the same cycle its previous service ends.
- **I_IEI falls while O_INT_n is low:** O_INT_n returns high one cycle later. pend is kept.
- **Multiple edges on one channel before acknowledge:** they collapse into a single pending request.

## Test plan
- **Single request:** NCH=4, I_VBASE=8'h40, I_IE=4'hF, pulse I_REQ[2]. Expect O_INT_n low 2 cycles later. Then raise I_SPM1. Expect O_VEC=8'h44, O_VEC_OE=1, O_ACK=4'b0100, O_IEO=0.
- **Priority:** I_REQ[3] and I_REQ[1] in the same cycle, one acknowledge. Expect O_VEC=8'h42 and insvc=4'b0010. After RETI, a second acknowledge gives O_VEC=8'h46.
- **Nesting:**
  - Channel 3 in service, then pulse I_REQ[0]. Expect O_INT_n low and acknowledge vector 8'h40.
  - First RETI clears insvc[0] only; O_IEO stays 0.
  - Second RETI clears insvc[3]; O_IEO returns to 1.
- **Chain gating:** I_IEI=0 with pend[1] set. Expect O_INT_n=1, O_IEO=0, and an I_RETI pulse ignored (insvc unchanged). Raise I_IEI: O_INT_n goes low in the next cycle.
- **Masking and boundaries:**
  - I_IE[2]=0 with a request on channel 2. Expect O_INT_n to stay 1. Raising I_IE[2] asserts /INT after 1 cycle.
  - I_REQ[2] edge in the same cycle as the channel 2 acknowledge. Expect pend[2] to remain set afterwards.
- **Reset mid-acknowledge:** assert I_RESET while O_VEC_OE=1. Expect O_VEC_OE=0, O_INT_n=1, O_VEC=8'h00, pend=insvc=0 on the next cycle.
